// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and offers
// one slot per cycle to Decode, turning an accepted taken branch into one cancelled slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h1c00_0000,
  parameter int          FD_BUS_Wid     = 33,
  parameter int          Branch_BUS_Wid = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      D_allowin,
  input  logic [Branch_BUS_Wid-1:0] Branch_BUS,
  output logic                      FD_valid,
  output logic [FD_BUS_Wid-1:0]     FD_BUS,
  output logic                      inst_sram_en,
  output logic [3:0]                inst_sram_we,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        d_busy_q, d_busy_d;
  logic        d_pc_en_q, d_pc_en_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] issue_pc;
  logic        issue_pc_en;
  logic        issue;
  logic        accept;

  assign br_taken  = Branch_BUS[32];
  assign br_target = Branch_BUS[31:0];

  assign issue_pc = (state_q == REDIR) ? tgt_q : pc_q + 32'd4;
  assign FD_valid = (state_q != IDLE);
  assign issue    = FD_valid & D_allowin & ~rst;

  // Only a live, non-cancelled branch leaving Decode can redirect.
  assign accept      = d_busy_q & d_pc_en_q & br_taken & D_allowin & ~rst;
  assign issue_pc_en = ~(accept & (state_q == RUN));

  assign FD_BUS          = {issue_pc, issue_pc_en};
  assign inst_sram_en    = issue;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = issue_pc;
  assign inst_sram_wdata = 32'b0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    d_busy_d  = d_busy_q;
    d_pc_en_d = d_pc_en_q;
    case (state_q)
      IDLE:  state_d = RUN;
      RUN: if (issue && accept) begin
        state_d = REDIR;
        tgt_d   = br_target;
      end
      REDIR: if (issue) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      pc_d      = issue_pc;
      d_busy_d  = 1'b1;
      d_pc_en_d = issue_pc_en;
    end else if (D_allowin) begin
      d_busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC - 32'd4;
      tgt_q     <= 32'd0;
      d_busy_q  <= 1'b0;
      d_pc_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      d_busy_q  <= d_busy_d;
      d_pc_en_q <= d_pc_en_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the pipeline corner cases,
// then random traffic checked against a fetch-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        D_allowin;
  logic [32:0] Branch_BUS;
  logic        FD_valid;
  logic [32:0] FD_BUS;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .D_allowin(D_allowin), .Branch_BUS(Branch_BUS),
    .FD_valid(FD_valid), .FD_BUS(FD_BUS), .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model of the fetch stream: is fetching enabled, the last PC
  // sent down, a pending redirect, and what Decode currently holds.
  bit        m_on;
  bit [31:0] m_last;
  bit        m_redir;
  bit [31:0] m_tgt;
  bit        m_dec_live;
  bit        m_dec_real;

  logic        a_valid, a_en, a_pe;
  logic [31:0] a_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic model_reset();
    m_on = 0; m_last = RESET_PC - 4; m_redir = 0; m_tgt = 0;
    m_dec_live = 0; m_dec_real = 0;
  endtask

  // One cycle: drive inputs, check against model at negedge, advance model at posedge.
  task automatic step(input bit r, input bit al, input bit bt, input bit [31:0] tgt);
    bit        e_valid, e_en, e_pe, take;
    bit [31:0] e_addr;
    rst = r; D_allowin = al; Branch_BUS = {bt, tgt};
    @(negedge clk);
    e_valid = m_on;
    e_en    = m_on && al && !r;
    e_addr  = m_redir ? m_tgt : m_last + 32'd4;
    take    = m_dec_live && m_dec_real && bt && al && !r;
    e_pe    = !(take && !m_redir);
    a_valid = FD_valid; a_en = inst_sram_en; a_addr = inst_sram_addr; a_pe = FD_BUS[0];
    chk("model_valid", {31'b0, FD_valid}, {31'b0, e_valid});
    chk("model_en", {31'b0, inst_sram_en}, {31'b0, e_en});
    chk("model_addr", inst_sram_addr, e_addr);
    chk("model_fdpc", FD_BUS[32:1], e_addr);
    chk("model_pc_en", {31'b0, FD_BUS[0]}, {31'b0, e_pe});
    chk("we_wdata", {inst_sram_we, inst_sram_wdata[27:0]}, 32'd0);
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (e_en) begin
        m_last = e_addr;
        if (m_redir) m_redir = 0;
        else if (take) begin m_redir = 1; m_tgt = tgt; end
        m_dec_live = 1; m_dec_real = e_pe;
      end else if (al) m_dec_live = 0;
      m_on = 1;
    end
    #1;
  endtask

  typedef struct {
    bit r, al, bt; bit [31:0] tgt;
    bit ev, ee; bit [31:0] ea; bit epe;
  } vec_t;
  vec_t tbl[27];

  initial begin
    // Directed corner cases: reset release, stall, branch, branch under stall,
    // stall in REDIR, reset in REDIR, and PC wrap through 0xffff_fffc.
    tbl[0]  = '{1,1,0,32'h0,          0,0,32'h1c000000,1};
    tbl[1]  = '{0,1,0,32'h0,          0,0,32'h1c000000,1};
    tbl[2]  = '{0,1,0,32'h0,          1,1,32'h1c000000,1};
    tbl[3]  = '{0,1,0,32'h0,          1,1,32'h1c000004,1};
    tbl[4]  = '{0,1,0,32'h0,          1,1,32'h1c000008,1};
    tbl[5]  = '{0,0,0,32'h0,          1,0,32'h1c00000c,1};
    tbl[6]  = '{0,0,0,32'h0,          1,0,32'h1c00000c,1};
    tbl[7]  = '{0,0,0,32'h0,          1,0,32'h1c00000c,1};
    tbl[8]  = '{0,1,0,32'h0,          1,1,32'h1c00000c,1};
    tbl[9]  = '{0,1,0,32'h0,          1,1,32'h1c000010,1};
    tbl[10] = '{0,1,1,32'h1c000100,   1,1,32'h1c000014,0};
    tbl[11] = '{0,1,1,32'h1c000100,   1,1,32'h1c000100,1};
    tbl[12] = '{0,0,1,32'h1c000200,   1,0,32'h1c000104,1};
    tbl[13] = '{0,0,1,32'h1c000200,   1,0,32'h1c000104,1};
    tbl[14] = '{0,1,1,32'h1c000200,   1,1,32'h1c000104,0};
    tbl[15] = '{0,0,0,32'h0,          1,0,32'h1c000200,1};
    tbl[16] = '{0,0,0,32'h0,          1,0,32'h1c000200,1};
    tbl[17] = '{0,1,1,32'h1c000300,   1,1,32'h1c000200,1};
    tbl[18] = '{0,1,1,32'h1c000400,   1,1,32'h1c000204,0};
    tbl[19] = '{1,1,1,32'h1c000400,   1,0,32'h1c000400,1};
    tbl[20] = '{0,1,0,32'h0,          0,0,32'h1c000000,1};
    tbl[21] = '{0,1,0,32'h0,          1,1,32'h1c000000,1};
    tbl[22] = '{0,1,0,32'h0,          1,1,32'h1c000004,1};
    tbl[23] = '{0,1,1,32'hfffffff8,   1,1,32'h1c000008,0};
    tbl[24] = '{0,1,0,32'h0,          1,1,32'hfffffff8,1};
    tbl[25] = '{0,1,0,32'h0,          1,1,32'hfffffffc,1};
    tbl[26] = '{0,1,0,32'h0,          1,1,32'h00000000,1};

    rst = 1; D_allowin = 0; Branch_BUS = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].r, tbl[i].al, tbl[i].bt, tbl[i].tgt);
      chk($sformatf("vec%0d_valid", i), {31'b0, a_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d_en", i),    {31'b0, a_en},    {31'b0, tbl[i].ee});
      chk($sformatf("vec%0d_addr", i),  a_addr,           tbl[i].ea);
      chk($sformatf("vec%0d_pc_en", i), {31'b0, a_pe},    {31'b0, tbl[i].epe});
    end

    for (int i = 0; i < 3000; i++) begin
      bit r, al, bt;
      r  = ($urandom_range(0, 99) < 2);
      al = ($urandom_range(0, 99) < 70);
      bt = ($urandom_range(0, 99) < 30);
      step(r, al, bt, {$urandom() & 32'hffff_fffc});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
